// File: rtl/conv_dot_engine_if.sv
// Beat/weight input and result output bundle for conv_dot_engine.
interface conv_dot_engine_if #(
  parameter int N  = 32,
  parameter int DW = 4,
  parameter int WW = 4,
  parameter int OW = 16
);
  logic            weight_valid;
  logic [N*WW-1:0] in_weight;
  logic            in_valid;
  logic [N*DW-1:0] in_ifm;
  logic            in_last;
  logic            relu_en;
  logic            out_valid;
  logic [OW-1:0]   out_data;
  logic            out_sat;

  modport slave (
    input  weight_valid, in_weight, in_valid, in_ifm, in_last, relu_en,
    output out_valid, out_data, out_sat
  );

  modport master (
    output weight_valid, in_weight, in_valid, in_ifm, in_last, relu_en,
    input  out_valid, out_data, out_sat
  );
endinterface

// File: rtl/conv_dot_engine.sv
// Pipelined N-lane dot-product engine: multiply, reduce, accumulate across beats,
// then emit a saturated (optionally ReLU'd) result on the last beat.
module conv_dot_engine #(
  parameter int N      = 32,
  parameter int DW     = 4,
  parameter int WW     = 4,
  parameter int OW     = 16,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  conv_dot_engine_if.slave   bus
);
  localparam int   PW  = DW + WW;
  localparam int   LN  = $clog2(N);
  localparam int   SW  = PW + LN;
  localparam logic SGN = (SIGNED != 0);

  logic [N*WW-1:0] weight_q, weight_d;
  logic [PW-1:0]   prod_q [N];
  logic [PW-1:0]   prod_d [N];
  logic            v1_q, v1_d, last1_q, last1_d, relu1_q, relu1_d;
  logic [SW-1:0]   sum_q, sum_d, sum_tree;
  logic            v2_q, v2_d, last2_q, last2_d, relu2_q, relu2_d;
  logic [OW-1:0]   acc_q, acc_d;
  logic            sticky_q, sticky_d;
  logic            out_valid_q, out_valid_d;
  logic [OW-1:0]   out_data_q, out_data_d;
  logic            out_sat_q, out_sat_d;

  logic [OW:0]     acc_ext, sum_ext, s_full;
  logic            ovf;
  logic [OW-1:0]   s_sat, s_out;

  // Both operands extended to the full product width, so the truncated product is exact.
  function automatic logic [PW-1:0] lane_mul(input logic [DW-1:0] a, input logic [WW-1:0] w);
    logic [PW-1:0] ea;
    logic [PW-1:0] ew;
    ea = {{WW{SGN & a[DW-1]}}, a};
    ew = {{DW{SGN & w[WW-1]}}, w};
    return ea * ew;
  endfunction

  // Stage 1: products use the weight register as it stood before this edge.
  always_comb begin
    weight_d = bus.weight_valid ? bus.in_weight : weight_q;
    v1_d     = bus.in_valid;
    last1_d  = bus.in_valid & bus.in_last;
    relu1_d  = bus.in_valid & bus.in_last & bus.relu_en;
    for (int unsigned k = 0; k < N; k++) begin
      prod_d[k] = bus.in_valid ? lane_mul(bus.in_ifm[k*DW +: DW], weight_q[k*WW +: WW])
                               : prod_q[k];
    end
  end

  // Stage 2: full-width reduction of the lane products.
  always_comb begin
    sum_tree = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum_tree = sum_tree + {{LN{SGN & prod_q[k][PW-1]}}, prod_q[k]};
    end
    sum_d   = v1_q ? sum_tree : sum_q;
    v2_d    = v1_q;
    last2_d = last1_q;
    relu2_d = relu1_q;
  end

  // Stage 3: accumulate in OW+1 bits so overflow is visible before clamping.
  always_comb begin
    acc_ext = {SGN & acc_q[OW-1], acc_q};
    sum_ext = {{(OW+1-SW){SGN & sum_q[SW-1]}}, sum_q};
    s_full  = acc_ext + sum_ext;
    if (SGN) begin
      ovf   = s_full[OW] ^ s_full[OW-1];
      s_sat = ovf ? (s_full[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}})
                  : s_full[OW-1:0];
    end else begin
      ovf   = s_full[OW];
      s_sat = ovf ? '1 : s_full[OW-1:0];
    end
    s_out = (SGN & relu2_q & s_sat[OW-1]) ? '0 : s_sat;

    acc_d       = acc_q;
    sticky_d    = sticky_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sat_d   = 1'b0;
    if (v2_q) begin
      if (last2_q) begin
        out_valid_d = 1'b1;
        out_data_d  = s_out;
        out_sat_d   = sticky_q | ovf;
        acc_d       = '0;
        sticky_d    = 1'b0;
      end else begin
        acc_d    = s_sat;
        sticky_d = sticky_q | ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_q    <= '0;
      for (int unsigned k = 0; k < N; k++) prod_q[k] <= '0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      relu1_q     <= 1'b0;
      sum_q       <= '0;
      v2_q        <= 1'b0;
      last2_q     <= 1'b0;
      relu2_q     <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      weight_q    <= weight_d;
      for (int unsigned k = 0; k < N; k++) prod_q[k] <= prod_d[k];
      v1_q        <= v1_d;
      last1_q     <= last1_d;
      relu1_q     <= relu1_d;
      sum_q       <= sum_d;
      v2_q        <= v2_d;
      last2_q     <= last2_d;
      relu2_q     <= relu2_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_conv_dot_engine.sv
// Scoreboard bench: an unsigned and a signed engine driven side by side against
// an arithmetic dot-product/accumulate model.
module tb_conv_dot_engine;
  localparam int N = 32, DW = 4, WW = 4, OW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_dot_engine_if #(.N(N), .DW(DW), .WW(WW), .OW(OW)) bus0 ();
  conv_dot_engine_if #(.N(N), .DW(DW), .WW(WW), .OW(OW)) bus1 ();

  conv_dot_engine #(.N(N), .DW(DW), .WW(WW), .OW(OW), .SIGNED(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  conv_dot_engine #(.N(N), .DW(DW), .WW(WW), .OW(OW), .SIGNED(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  typedef struct { logic [OW-1:0] data; logic sat; int due; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int vectors = 0, miscompares = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus for the next edge, per engine
  bit  wv [2];
  int  wl [2][N];
  bit  iv [2];
  int  xl [2][N];
  bit  lst[2];
  bit  rl [2];
  // Reference model state
  int     mw    [2][N];
  longint acc   [2];
  bit     sticky[2];

  function automatic int sx(int id, int v);
    return (id == 1 && v >= 8) ? v - 16 : v;
  endfunction

  task automatic check(string name, int id, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, id, act, exp, $time);
    end
  endtask

  task automatic model_step(int id);
    longint dot, s, lo, hi, o;
    bit sat;
    exp_t e;
    lo = (id == 1) ? -32768 : 0;
    hi = (id == 1) ? 32767 : 65535;
    if (iv[id]) begin
      dot = 0;
      for (int k = 0; k < N; k++) dot += longint'(sx(id, xl[id][k]) * sx(id, mw[id][k]));
      s = acc[id] + dot;
      sat = 0;
      if (s > hi) begin s = hi; sat = 1; end
      if (s < lo) begin s = lo; sat = 1; end
      sticky[id] |= sat;
      if (lst[id]) begin
        o = s;
        if (id == 1 && rl[id] && o < 0) o = 0;
        e.data = OW'(o);
        e.sat  = sticky[id];
        e.due  = cyc + 3;
        if (id == 0) q0.push_back(e); else q1.push_back(e);
        acc[id] = 0;
        sticky[id] = 0;
      end else begin
        acc[id] = s;
      end
    end
    if (wv[id]) for (int k = 0; k < N; k++) mw[id][k] = wl[id][k];
  endtask

  // Called at a negedge: apply stimulus, step model, advance one clock.
  task automatic drive();
    bus0.weight_valid = wv[0]; bus0.in_valid = iv[0]; bus0.in_last = lst[0]; bus0.relu_en = rl[0];
    bus1.weight_valid = wv[1]; bus1.in_valid = iv[1]; bus1.in_last = lst[1]; bus1.relu_en = rl[1];
    for (int k = 0; k < N; k++) begin
      bus0.in_weight[k*WW +: WW] = WW'(wl[0][k]);
      bus0.in_ifm[k*DW +: DW]    = DW'(xl[0][k]);
      bus1.in_weight[k*WW +: WW] = WW'(wl[1][k]);
      bus1.in_ifm[k*DW +: DW]    = DW'(xl[1][k]);
    end
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
    for (int id = 0; id < 2; id++) begin
      wv[id] = 0; iv[id] = 0; lst[id] = 0; rl[id] = 0;
    end
  endtask

  task automatic idle(int n);
    repeat (n) drive();
  endtask

  task automatic set_w(int id, int val);
    wv[id] = 1;
    for (int k = 0; k < N; k++) wl[id][k] = val;
  endtask

  task automatic set_x(int id, int val, bit last, bit relu);
    iv[id] = 1; lst[id] = last; rl[id] = relu;
    for (int k = 0; k < N; k++) xl[id][k] = val;
  endtask

  task automatic mon(int id, logic v, logic [OW-1:0] d, logic s);
    exp_t e;
    int   n;
    if (v) begin
      n = (id == 0) ? q0.size() : q1.size();
      if (n == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out_valid dut%0d: got out_valid=1 data=%0d required no result (t=%0t)",
                 id, d, $time);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        check("latency_cycle", id, cyc, e.due);
        check("out_data", id, d, e.data);
        check("out_sat", id, s, e.sat);
      end
    end else begin
      check("idle_out_sat", id, s, 0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus0.out_valid, bus0.out_data, bus0.out_sat);
    mon(1, bus1.out_valid, bus1.out_data, bus1.out_sat);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    for (int id = 0; id < 2; id++) begin
      acc[id] = 0; sticky[id] = 0;
      for (int k = 0; k < N; k++) mw[id][k] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 0, bus0.out_valid, 0);
    check("rst_out_data",  0, bus0.out_data, 0);
    check("rst_out_valid", 1, bus1.out_valid, 0);
    check("rst_out_data",  1, bus1.out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int rate;
    rst_n = 1'b1;
    for (int id = 0; id < 2; id++) begin
      wv[id] = 0; iv[id] = 0; lst[id] = 0; rl[id] = 0;
      for (int k = 0; k < N; k++) begin wl[id][k] = 0; xl[id][k] = 0; end
    end
    drive_idle_bus();
    #2;
    do_reset();

    // All ones: 32, three cycles after the beat
    set_w(0, 1); drive();
    set_x(0, 1, 1, 0); drive();
    idle(5);

    // Three back-to-back full-scale beats, then an immediate fresh product
    set_w(0, 15); drive();
    for (int b = 1; b <= 3; b++) begin set_x(0, 15, b == 3, 0); drive(); end
    set_x(0, 1, 1, 0); drive();
    idle(5);

    // Ten beats with random gaps saturate; next product starts clean
    for (int b = 1; b <= 10; b++) begin
      set_x(0, 15, b == 10, 0); drive();
      idle($urandom_range(0, 3));
    end
    set_x(0, 0, 1, 0); drive();
    idle(5);

    // Weight load on the same edge as a beat: old weights used by that beat
    set_w(0, 1); drive();
    set_w(0, 2); set_x(0, 1, 1, 0); drive();
    set_x(0, 1, 1, 0); drive();
    idle(5);

    // Signed: -1792, then ReLU to 0; then negative saturation with and without ReLU
    set_w(1, 7); drive();
    set_x(1, 8, 1, 0); drive();
    set_x(1, 8, 1, 1); drive();
    for (int b = 1; b <= 20; b++) begin set_x(1, 8, b == 20, 0); drive(); end
    for (int b = 1; b <= 20; b++) begin set_x(1, 8, b == 20, 1); drive(); end
    set_w(1, 7);
    for (int b = 1; b <= 20; b++) begin set_x(1, 7, b == 20, 0); drive(); end
    idle(5);

    // Reset mid-product discards partial sums and in-flight beats
    set_x(0, 3, 0, 0); set_x(1, 3, 0, 0); drive();
    set_x(0, 3, 0, 0); set_x(1, 3, 0, 0); drive();
    do_reset();
    set_w(0, 1); set_w(1, 1); drive();
    set_x(0, 1, 1, 0); set_x(1, 1, 1, 0); drive();
    idle(5);

    // Randomised traffic: short products then long, saturation-prone ones
    for (int ph = 0; ph < 2; ph++) begin
      rate = (ph == 0) ? 3 : 40;
      for (int c = 0; c < 1500; c++) begin
        for (int id = 0; id < 2; id++) begin
          if ($urandom_range(0, 15) == 0) begin
            wv[id] = 1;
            for (int k = 0; k < N; k++)
              wl[id][k] = (ph == 1 && $urandom_range(0, 1) == 1) ? (id == 1 ? 8 : 15)
                                                                 : int'($urandom_range(0, 15));
          end
          iv[id]  = ($urandom_range(0, 3) != 0);
          lst[id] = ($urandom_range(0, rate - 1) == 0);
          rl[id]  = ($urandom_range(0, 1) == 1);
          for (int k = 0; k < N; k++)
            xl[id][k] = (ph == 1 && $urandom_range(0, 1) == 1) ? (id == 1 ? 7 : 15)
                                                               : int'($urandom_range(0, 15));
        end
        drive();
      end
      for (int id = 0; id < 2; id++) begin set_x(id, 0, 1, 0); end
      drive();
      idle(5);
    end

    idle(8);
    check("scoreboard_drained", 0, q0.size(), 0);
    check("scoreboard_drained", 1, q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic drive_idle_bus();
    bus0.weight_valid = 0; bus0.in_valid = 0; bus0.in_last = 0; bus0.relu_en = 0;
    bus0.in_weight = '0; bus0.in_ifm = '0;
    bus1.weight_valid = 0; bus1.in_valid = 0; bus1.in_last = 0; bus1.relu_en = 0;
    bus1.in_weight = '0; bus1.in_ifm = '0;
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule
